// File: rtl/pdp8_bus_pkg.sv
// pdp8_bus_pkg: beat-field constants, bus FSM states and default I/O device address
package pdp8_bus_pkg;
  localparam int ADDR_BEAT = 7;
  localparam int HI_SEL = 6;
  localparam int WRITE_BIT = 4;
  localparam logic [1:0] IDX_N0 = 2'd0;
  localparam logic [1:0] IDX_N1 = 2'd1;
  localparam logic [1:0] IDX_N2 = 2'd2;
  localparam logic [1:0] IDX_IO = 2'd3;
  localparam logic [8:0] IO_DEV_DEFAULT = 9'h003;
  typedef enum logic [2:0] {IDLE, AL, AH, IO, D0, D1} bus_state_e;
endpackage

// File: rtl/pdp8_io_reg.sv
// pdp8_io_reg: valid/ready holding register with full flag and overrun detect
module pdp8_io_reg #(
  parameter int W = 12,
  parameter bit OVR_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ld,
  input  logic [W-1:0] ld_data,
  input  logic         drain,
  output logic         full,
  output logic [W-1:0] data,
  output logic         ovr
);
  logic take;
  assign take = ld & (!full | drain);
  assign ovr = OVR_EN & ld & full & !drain;
  // a load is taken when empty or when the held word leaves in the same cycle
  always_ff @(posedge clk)
    if (reset) begin
      full <= 1'b0;
      data <= '0;
    end else begin
      full <= take | (full & !drain);
      if (take) data <= ld_data;
    end
endmodule

// File: rtl/pdp8_bus_slave.sv
// pdp8_bus_slave: nibble-bus memory/I-O target; optional irq via PDP8_BUS_IRQ_EN
module pdp8_bus_slave
  import pdp8_bus_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter logic [8:0] IO_DEV = IO_DEV_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  bus_out,
  output logic [3:0]  bus_in,
  output logic [11:0] dev_out_data,
  output logic        dev_out_valid,
  input  logic        dev_out_ready,
  input  logic [11:0] dev_in_data,
  input  logic        dev_in_valid,
  output logic        dev_in_ready,
  output logic        irq,
  output logic        proto_err
);
  localparam int AW = ADDR_W > 9 ? ADDR_W : 9;
  bus_state_e state, state_d;
  logic [AW-1:0] addr;
  logic [7:0] stage;
  logic [11:0] mem [2**ADDR_W];
  logic [11:0] in_data, rd_word, wdata;
  logic [3:0] nib, rd_nib;
  logic [1:0] idx;
  logic is_addr, hi_sel, wr, ok, io_q, io_hit, commit;
  logic mem_we, io_wr, io_rd, in_full, out_full, in_ovr, out_ovr;
  assign is_addr = bus_out[ADDR_BEAT];
  assign hi_sel = bus_out[HI_SEL];
  assign idx = bus_out[6:5];
  assign wr = bus_out[WRITE_BIT];
  assign nib = bus_out[3:0];
  assign io_hit = io_q && addr[8:0] == IO_DEV;
  assign rd_word = io_q ? (io_hit ? in_data : 12'h000) : mem[addr[ADDR_W-1:0]];
  assign rd_nib = idx == IDX_N0 ? rd_word[11:8] : idx == IDX_N1 ? rd_word[7:4] : rd_word[3:0];
  assign bus_in = (!ok || is_addr || (wr && idx != IDX_IO)) ? 4'h0 :
                  idx == IDX_IO ? {3'b000, wr ? !out_full : in_full} : rd_nib;
  assign commit = ok && !is_addr && idx == IDX_N2;
  assign wdata = {nib, stage};
  assign mem_we = commit && wr && !io_q && !reset;
  assign io_wr = commit && wr && io_hit;
  assign io_rd = commit && !wr && io_hit;
  assign dev_in_ready = !in_full;
  assign dev_out_valid = out_full;
  // beat legality and next state; an illegal beat is dropped and the FSM falls back to IDLE
  always_comb begin
    ok = 1'b0;
    state_d = IDLE;
    if (is_addr && !hi_sel) begin
      ok = 1'b1;
      state_d = AL;
    end else if (is_addr) begin
      ok = state == AL;
      if (ok) state_d = AH;
    end else if (idx == IDX_IO) begin
      ok = state == AH;
      if (ok) state_d = IO;
    end else if (idx == IDX_N0) begin
      ok = state == AH || state == IO;
      if (ok) state_d = D0;
    end else if (idx == IDX_N1) begin
      ok = state == D0;
      if (ok) state_d = D1;
    end else begin
      ok = state == D1;
    end
  end
  // bus FSM state register
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_d;
  // address latch, I/O-space flag, write staging and sticky error
  always_ff @(posedge clk)
    if (reset) begin
      addr <= '0;
      io_q <= 1'b0;
      stage <= '0;
      proto_err <= 1'b0;
    end else begin
      if (ok && is_addr && !hi_sel) begin
        addr[5:0] <= bus_out[5:0];
        io_q <= 1'b0;
      end
      if (ok && is_addr && hi_sel) addr[AW-1:6] <= bus_out[AW-7:0];
      if (ok && !is_addr && idx == IDX_IO) io_q <= 1'b1;
      if (ok && !is_addr && wr && idx == IDX_N0) stage[3:0] <= nib;
      if (ok && !is_addr && wr && idx == IDX_N1) stage[7:4] <= nib;
      proto_err <= proto_err | !ok | out_ovr | in_ovr;
    end
  // word memory, written on the final write nibble; contents survive reset
  always_ff @(posedge clk)
    if (mem_we) mem[addr[ADDR_W-1:0]] <= wdata;
  pdp8_io_reg #(.W(12), .OVR_EN(1'b0)) u_in (
    .clk(clk), .reset(reset), .ld(dev_in_valid), .ld_data(dev_in_data), .drain(io_rd),
    .full(in_full), .data(in_data), .ovr(in_ovr)
  );
  pdp8_io_reg #(.W(12), .OVR_EN(1'b1)) u_out (
    .clk(clk), .reset(reset), .ld(io_wr), .ld_data(wdata), .drain(out_full & dev_out_ready),
    .full(out_full), .data(dev_out_data), .ovr(out_ovr)
  );
`ifdef PDP8_BUS_IRQ_EN
  logic pend;
  // output-drained pending flag and registered interrupt request
  always_ff @(posedge clk)
    if (reset) begin
      pend <= 1'b0;
      irq <= 1'b0;
    end else begin
      pend <= io_wr ? 1'b0 : (out_full & dev_out_ready) ? 1'b1 : pend;
      irq <= in_full | pend;
    end
`else
  assign irq = 1'b0;
`endif
endmodule
